// File: rtl/dave_tone.sv
`default_nettype none
// ============================================================================
// Module   : dave_tone
// Purpose  : Dave tone-generator timebase for channels 0..2. Three CW-bit
//            period registers (I/O ports A0h-A5h) and a sync register (A7h)
//            drive three down-counters that advance on the ceirq tick. Each
//            reload toggles the channel's square wave; channels 0 and 1 also
//            raise a single-tick interrupt strobe.
// Ports    : clock  - system clock
//            reset  - synchronous reset, active-high
//            cecpu  - CPU-side clock enable, qualifies I/O writes
//            ceirq  - 250 kHz tick enable, advances the counters
//            iorq   - Z80 IORQ (active-low)
//            wr     - Z80 WR (active-low)
//            a      - I/O port address (low byte)
//            d      - CPU write data
//            tone0..tone2 - square-wave outputs to the sound mixer
//            irq0, irq1   - reload strobes for channels 0 and 1
// Revision : 1.0 - initial release
// ============================================================================
module dave_tone #(
  parameter int              CW   = 12,
  parameter logic [CW-1:0]   RSTP = '0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cecpu,
  input  logic       ceirq,
  input  logic       iorq,
  input  logic       wr,
  input  logic [7:0] a,
  input  logic [7:0] d,
  output logic       tone0,
  output logic       tone1,
  output logic       tone2,
  output logic       irq0,
  output logic       irq1
);

  logic [2:0][CW-1:0] r_per;
  logic [2:0][CW-1:0] r_cnt;
  logic [2:0]         r_sync;
  logic [2:0]         r_tone;
  logic [1:0]         r_irq;

  logic               w_wr;
  logic [2:0]         w_reload;

  assign w_wr = cecpu & ~iorq & ~wr;

  // A channel reloads when its counter has reached zero and it is not held
  // in sync; sync forces a reload every tick but suppresses the event.
  generate
    for (genvar g = 0; g < 3; g++) begin : g_reload
      assign w_reload[g] = ~r_sync[g] & (r_cnt[g] == '0);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < 3; n++) begin
        r_per[n] <= RSTP;
        r_cnt[n] <= '0;
      end
      r_sync <= '0;
      r_tone <= '0;
      r_irq  <= '0;
    end else begin
      // Counter update reads the register values from before any write in
      // this same clock, so a period change never restarts a countdown.
      if (ceirq) begin
        for (int n = 0; n < 3; n++) begin
          if (r_sync[n]) begin
            r_cnt[n]  <= r_per[n];
            r_tone[n] <= 1'b0;
          end else if (r_cnt[n] == '0) begin
            r_cnt[n]  <= r_per[n];
            r_tone[n] <= ~r_tone[n];
          end else begin
            r_cnt[n]  <= r_cnt[n] - 1'b1;
          end
        end
        r_irq <= w_reload[1:0];
      end

      if (w_wr) begin
        case (a)
          8'hA0:   r_per[0][7:0]    <= d;
          8'hA1:   r_per[0][CW-1:8] <= d[CW-9:0];
          8'hA2:   r_per[1][7:0]    <= d;
          8'hA3:   r_per[1][CW-1:8] <= d[CW-9:0];
          8'hA4:   r_per[2][7:0]    <= d;
          8'hA5:   r_per[2][CW-1:8] <= d[CW-9:0];
          8'hA7:   r_sync           <= d[2:0];
          default: ;
        endcase
      end
    end
  end

  assign tone0 = r_tone[0];
  assign tone1 = r_tone[1];
  assign tone2 = r_tone[2];
  assign irq0  = r_irq[0];
  assign irq1  = r_irq[1];

endmodule
`default_nettype wire

// File: tb/tb_dave_tone.sv
`default_nettype none
// ============================================================================
// Module   : tb_dave_tone
// Purpose  : Self-checking bench for dave_tone. The reference model schedules
//            each channel's next reload as an absolute tick number
//            (reload tick + period + 1) instead of counting down.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dave_tone;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cecpu = 1'b0;
  logic       ceirq = 1'b0;
  logic       iorq  = 1'b1;
  logic       wr    = 1'b1;
  logic [7:0] a     = 8'h00;
  logic [7:0] d     = 8'h00;
  logic       tone0, tone1, tone2, irq0, irq1;

  always #5 clock = ~clock;

  dave_tone #(.CW(12), .RSTP(12'h000)) dut (
    .clock(clock), .reset(reset), .cecpu(cecpu), .ceirq(ceirq),
    .iorq(iorq), .wr(wr), .a(a), .d(d),
    .tone0(tone0), .tone1(tone1), .tone2(tone2), .irq0(irq0), .irq1(irq1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int       m_p [3];
  bit [2:0] m_s;
  bit [2:0] m_tone;
  bit [1:0] m_irq;
  longint   m_next [3];
  longint   tk = 0;

  function automatic logic [4:0] dut_v();
    return {tone2, tone1, tone0, irq1, irq0};
  endfunction

  function automatic logic [4:0] mdl_v();
    return {m_tone, m_irq};
  endfunction

  // One clock: drive inputs, advance the model at the edge, settle at negedge.
  task automatic cyc(input bit rst, input bit ce, input bit cpu, input bit iorq_n,
                     input bit wr_n, input logic [7:0] ad, input logic [7:0] dd);
    bit [2:0] ev;
    reset = rst; ceirq = ce; cecpu = cpu; iorq = iorq_n; wr = wr_n; a = ad; d = dd;
    @(posedge clock);
    if (rst) begin
      for (int n = 0; n < 3; n++) begin
        m_p[n]    = 0;
        m_next[n] = tk + 1;
      end
      m_s = '0; m_tone = '0; m_irq = '0;
    end else begin
      if (ce) begin
        tk++;
        ev = '0;
        for (int n = 0; n < 3; n++) begin
          if (m_s[n]) begin
            m_tone[n] = 1'b0;
            m_next[n] = tk + m_p[n] + 1;
          end else if (tk == m_next[n]) begin
            m_tone[n] = ~m_tone[n];
            ev[n]     = 1'b1;
            m_next[n] = tk + m_p[n] + 1;
          end
        end
        m_irq = ev[1:0];
      end
      if (cpu && !iorq_n && !wr_n) begin
        case (ad)
          8'hA0: m_p[0] = (m_p[0] & 'hF00) | int'(dd);
          8'hA1: m_p[0] = (m_p[0] & 'h0FF) | (int'(dd & 8'h0F) << 8);
          8'hA2: m_p[1] = (m_p[1] & 'hF00) | int'(dd);
          8'hA3: m_p[1] = (m_p[1] & 'h0FF) | (int'(dd & 8'h0F) << 8);
          8'hA4: m_p[2] = (m_p[2] & 'hF00) | int'(dd);
          8'hA5: m_p[2] = (m_p[2] & 'h0FF) | (int'(dd & 8'h0F) << 8);
          8'hA7: m_s    = dd[2:0];
          default: ;
        endcase
      end
    end
    @(negedge clock);
  endtask

  task automatic wreg(input logic [7:0] ad, input logic [7:0] dd);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ad, dd);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA7, 8'h07);
    n_cmp++;
    if (dut_v() !== 5'b00000) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 00000", dut_v());
    end
  endtask

  // P0=4 with a tick every 4th clock: toggle every 5 ticks, irq0 4 clocks wide.
  task automatic test_period_p4();
    longint last_tog = -1;
    int     run = 0;
    logic   prev_t0;
    do_reset();
    wreg(8'hA0, 8'h04);
    wreg(8'hA1, 8'h00);
    prev_t0 = tone0;
    for (int c = 0; c < 200; c++) begin
      cyc(1'b0, (c % 4) == 3, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      n_cmp++;
      if (dut_v() !== mdl_v()) begin
        n_bad++; $display("FAIL p4_model c=%0d: got %b want %b", c, dut_v(), mdl_v());
      end
      if (tone0 !== prev_t0) begin
        if (last_tog >= 0) begin
          n_cmp++;
          if (tk - last_tog != 5) begin
            n_bad++; $display("FAIL p4_halfperiod: got %0d ticks want 5", tk - last_tog);
          end
        end
        last_tog = tk;
      end
      prev_t0 = tone0;
      if (irq0 === 1'b1) run++;
      else if (run != 0) begin
        n_cmp++;
        if (run != 4) begin
          n_bad++; $display("FAIL p4_irq_width: got %0d clocks want 4", run);
        end
        run = 0;
      end
    end
  endtask

  // P1=FFFh (upper nibble of data dropped): 4096-tick half period.
  task automatic test_period_max();
    longint last_tog = -1;
    int     togs = 0;
    logic   prev_t1;
    do_reset();
    wreg(8'hA2, 8'hFF);
    wreg(8'hA3, 8'hFF);
    prev_t1 = tone1;
    for (int c = 0; c < 8400; c++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      n_cmp++;
      if (dut_v() !== mdl_v()) begin
        n_bad++; $display("FAIL pmax_model c=%0d: got %b want %b", c, dut_v(), mdl_v());
      end
      if (tone1 !== prev_t1) begin
        togs++;
        if (last_tog >= 0) begin
          n_cmp++;
          if (tk - last_tog != 4096) begin
            n_bad++; $display("FAIL pmax_halfperiod: got %0d ticks want 4096", tk - last_tog);
          end
        end
        last_tog = tk;
      end
      prev_t1 = tone1;
    end
    n_cmp++;
    if (togs != 3) begin
      n_bad++; $display("FAIL pmax_toggles: got %0d want 3", togs);
    end
  endtask

  // Sync holds channel 0 low; leaving sync gives first reload 10 ticks later.
  task automatic test_sync();
    int tone1_togs = 0;
    int first = -1;
    logic prev_t1;
    do_reset();
    wreg(8'hA0, 8'h09); wreg(8'hA1, 8'h00);
    wreg(8'hA2, 8'h03); wreg(8'hA3, 8'h00);
    for (int c = 0; c < 25; c++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    wreg(8'hA7, 8'h01);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    prev_t1 = tone1;
    for (int c = 0; c < 40; c++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      n_cmp++;
      if ({tone0, irq0} !== 2'b00 || dut_v() !== mdl_v()) begin
        n_bad++; $display("FAIL sync_hold c=%0d: got %b want %b", c, dut_v(), mdl_v());
      end
      if (tone1 !== prev_t1) tone1_togs++;
      prev_t1 = tone1;
    end
    n_cmp++;
    if (tone1_togs != 10) begin
      n_bad++; $display("FAIL sync_ch1_free: got %0d toggles want 10", tone1_togs);
    end
    wreg(8'hA7, 8'h00);
    for (int k = 1; k <= 20 && first < 0; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      if (irq0 === 1'b1) begin
        first = k;
        n_cmp++;
        if (tone0 !== 1'b1) begin
          n_bad++; $display("FAIL sync_release_tone: got %b want 1", tone0);
        end
      end
    end
    n_cmp++;
    if (first != 10) begin
      n_bad++; $display("FAIL sync_release_delay: got %0d ticks want 10", first);
    end
  endtask

  // Period write mid-countdown (P0=9, C0=6) finishes old countdown first.
  task automatic test_midwrite();
    int rises [$];
    do_reset();
    wreg(8'hA0, 8'h09);
    wreg(8'hA7, 8'h01);
    for (int c = 0; c < 2; c++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    wreg(8'hA7, 8'h00);
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    wreg(8'hA0, 8'h02);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      if (irq0 === 1'b1) rises.push_back(k);
    end
    n_cmp++;
    if (rises.size() < 3 || rises[0] != 7 || rises[1] != 10 || rises[2] != 13) begin
      n_bad++;
      $display("FAIL midwrite_reloads: got %p want 7,10,13", rises);
    end
  endtask

  // A4h write coincident with a reloading tick: old P2 loaded, new one next.
  task automatic test_back_to_back();
    int   togs [$];
    logic prev_t2;
    do_reset();
    wreg(8'hA4, 8'h05); wreg(8'hA5, 8'h00);
    for (int c = 0; c < 6; c++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    prev_t2 = tone2;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA4, 8'h02);
    n_cmp++;
    if (tone2 === prev_t2) begin
      n_bad++; $display("FAIL same_cycle_reload: got tone2=%b want toggle", tone2);
    end
    prev_t2 = tone2;
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      if (tone2 !== prev_t2) togs.push_back(k);
      prev_t2 = tone2;
    end
    n_cmp++;
    if (togs.size() < 2 || togs[0] != 6 || togs[1] != 9) begin
      n_bad++; $display("FAIL same_cycle_periods: got %p want 6,9", togs);
    end
  endtask

  // Reset with tones high: everything clears, P=0 after release.
  task automatic test_reset_mid();
    do_reset();
    wreg(8'hA0, 8'h02); wreg(8'hA2, 8'h03); wreg(8'hA4, 8'h04);
    for (int c = 0; c < 2; c++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    n_cmp++;
    if ({tone2, tone1, tone0} !== 3'b111) begin
      n_bad++; $display("FAIL rmid_pre: got %b want 111", {tone2, tone1, tone0});
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 8'h07);
    n_cmp++;
    if (dut_v() !== 5'b00000) begin
      n_bad++; $display("FAIL rmid_cleared: got %b want 00000", dut_v());
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    n_cmp++;
    if (dut_v() !== 5'b11111) begin
      n_bad++; $display("FAIL rmid_first_tick: got %b want 11111", dut_v());
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    n_cmp++;
    if (dut_v() !== 5'b00011) begin
      n_bad++; $display("FAIL rmid_p_zero: got %b want 00011", dut_v());
    end
  endtask

  // Random bus traffic, ticks, freezes and resets against the model.
  task automatic test_random();
    logic [7:0] addrs [9];
    logic [7:0] ad, dd;
    addrs = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'h00};
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      ad = addrs[$urandom_range(0, 8)];
      if (ad == 8'h00) ad = 8'($urandom);
      if (ad[0] == 1'b1 && ad != 8'hA7) dd = ($urandom % 8 == 0) ? 8'($urandom) : 8'hF0;
      else dd = 8'($urandom_range(0, 15)) | ($urandom % 16 == 0 ? 8'hF0 : 8'h00);
      cyc(($urandom % 300) == 0, ($urandom % 3) == 0, 1'($urandom),
          ($urandom % 4) == 0, ($urandom % 4) == 0, ad, dd);
      n_cmp++;
      if (dut_v() !== mdl_v()) begin
        n_bad++; $display("FAIL random c=%0d: got %b want %b", c, dut_v(), mdl_v());
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_period_p4();
    test_period_max();
    test_sync();
    test_midwrite();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
